// File: rtl/cic3_decim_if.sv
// cic3_decim_if: bitstream-in / PCM-out port bundle for the CIC decimator
interface cic3_decim_if #(parameter int OUT_WIDTH = 16);
  logic en;
  logic in;
  logic [OUT_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_sat;
  modport master(output en, in, input out_data, out_valid, out_sat);
  modport slave(input en, in, output out_data, out_valid, out_sat);
endinterface

// File: rtl/cic3_decim.sv
// cic3_decim: third-order CIC decimator turning a 1-bit delta-sigma stream into unsigned PCM
module cic3_decim #(
  parameter int LOG2R = 6,
  parameter int OUT_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  cic3_decim_if.slave s
);
  localparam int ACC_W = 3*LOG2R + 1;
  localparam int SH = 3*LOG2R - OUT_WIDTH;
  logic [ACC_W-1:0] i1, i2, i3, d1, d2, d3, sm, c1, c2, c3, y;
  logic [LOG2R-1:0] cnt;
  logic ev, sat;
  // registers wrap modulo 2^ACC_W; the comb differences undo the wrap exactly
  always_comb begin
    sm = i3 + i2;
    c1 = sm - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
    y = c3 >> SH;
    ev = s.en && (&cnt);
    sat = |y[ACC_W-1:OUT_WIDTH];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      cnt <= '0;
      s.out_data <= '0;
      s.out_valid <= 1'b0;
      s.out_sat <= 1'b0;
    end else begin
      s.out_valid <= ev;
      if (s.en) begin
        i1 <= i1 + {{(ACC_W-1){1'b0}}, s.in};
        i2 <= i2 + i1;
        i3 <= sm;
        cnt <= cnt + 1'b1;
      end
      if (ev) begin
        d1 <= sm;
        d2 <= c1;
        d3 <= c2;
        s.out_data <= sat ? '1 : y[OUT_WIDTH-1:0];
        s.out_sat <= sat;
      end
    end
  end
endmodule

// File: tb/tb_cic3_decim.sv
// tb_cic3_decim: directed bench checking the decimator against a boxcar-cubed FIR model
module tb_cic3_decim;
  localparam int LOG2R = 6;
  localparam int OUT_WIDTH = 16;
  localparam int R = 1 << LOG2R;
  localparam int SH = 3*LOG2R - OUT_WIDTH;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  cic3_decim_if #(.OUT_WIDTH(OUT_WIDTH)) bus();
  cic3_decim #(.LOG2R(LOG2R), .OUT_WIDTH(OUT_WIDTH)) dut(.clk(clk), .rstn(rstn), .s(bus));
  int h [0:3*R+1];
  bit hist [0:8191];
  int nen = 0;
  bit exp_valid = 1'b0;
  int passed = 0, total = 0;
  int last_y = 0, ym = 0;
  bit last_sat = 1'b0;
  int pulses = 0, cyc = 0, last_pulse = 0, spacing = 0;
  longint sum64 = 0, hs = 0, mean = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // impulse response: three length-R boxcars convolved, delayed by the 2-sample integrator pipeline
  function automatic int model_y(input int n);
    longint c = 0;
    for (int j = (n > 3*R ? n - 3*R : 0); j < n; j++) if (hist[j]) c += h[n-1-j];
    return int'(c >> SH);
  endfunction

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      nen <= 0;
      exp_valid <= 1'b0;
    end else if (bus.en) begin
      hist[nen] <= bus.in;
      nen <= nen + 1;
      exp_valid <= ((nen + 1) % R == 0);
    end else exp_valid <= 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      last_y = 0;
      pulses = 0;
      chk("rst_data", bus.out_data, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_sat", bus.out_sat, 0);
    end else begin
      chk("valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        ym = model_y(nen);
        last_sat = ym >= (1 << OUT_WIDTH);
        last_y = last_sat ? (1 << OUT_WIDTH) - 1 : ym;
        pulses++;
        if (pulses >= 5 && pulses < 69) sum64 += last_y;
        spacing = cyc - last_pulse;
        last_pulse = cyc;
        chk("sat", bus.out_sat, last_sat);
      end
      chk("data", bus.out_data, last_y);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    bus.en = 1'b0;
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  task automatic run(input int kind, input int nbits, input bit gap);
    bit b;
    int acc = 0;
    for (int i = 0; i < nbits; i++) begin
      if (kind == 4) begin
        b = (acc + 'h3000) >= 'h10000;
        acc = (acc + 'h3000) & 'hFFFF;
      end else b = kind == 1 ? (i % 2 == 0) : kind == 2 ? (i % 4 == 0) : kind == 3;
      step();
      bus.en = 1'b1;
      bus.in = b;
      if (gap) begin
        step();
        bus.en = 1'b0;
        bus.in = 1'($urandom_range(0, 1));
      end
    end
    step();
    bus.en = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.in = 1'b0;
    for (int t = 0; t <= 3*R+1; t++) h[t] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c+2]++;
    for (int t = 0; t <= 3*R+1; t++) hs += h[t];
    chk("h_sum", hs, R*R*R);
    chk("h_first", h[2], 1);
    chk("h_lead", h[1], 0);
    #1 rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    run(0, 6*R, 0);
    chk("zeros_data", bus.out_data, 0);
    chk("zeros_sat", last_sat, 0);
    chk("zeros_spacing", spacing, R);
    do_reset();
    run(1, 6*R, 0);
    chk("alt_data", bus.out_data, 'h8000);
    chk("alt_pulses", pulses, 6);
    do_reset();
    run(2, 6*R, 0);
    chk("p1000_data", bus.out_data, 'h4000);
    run(3, 5*R, 0);
    chk("ones_data", bus.out_data, 'hFFFF);
    chk("ones_sat", last_sat, 1);
    do_reset();
    run(1, 6*R, 1);
    chk("gap_data", bus.out_data, 'h8000);
    chk("gap_spacing", spacing, 2*R);
    do_reset();
    sum64 = 0;
    run(4, 69*R, 0);
    mean = sum64 / 64;
    chk("loop_mean_in_range", longint'(mean >= 'h3000 - 'h40 && mean <= 'h3000 + 'h40), 1);
    chk("loop_last", bus.out_data, 'h3000);
    do_reset();
    run(3, 30, 0);
    step();
    bus.en = 1'b1;
    bus.in = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sat", bus.out_sat, 0);
    repeat (2) step();
    bus.en = 1'b0;
    rstn = 1'b1;
    run(1, 6*R, 0);
    chk("mid_alt_data", bus.out_data, 'h8000);
    chk("mid_pulses", pulses, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
